// File: rtl/div_pkg.sv
// Shared types and constants for the divider issue front end.
package div_pkg;

  // bit1 selects the remainder, bit0 selects a signed divide.
  typedef struct packed {
    logic is_mod;
    logic is_signed;
  } div_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE,
    ST_KILL_REQ,
    ST_KILL_WAIT
  } div_state_e;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  function automatic logic [31:0] sel_result(input div_op_t op,
                                             input logic [31:0] q,
                                             input logic [31:0] s);
    return op.is_mod ? s : q;
  endfunction

endpackage

// File: rtl/div_issue_ctrl_fast.sv
// Combinational detection of results that need no divider: zero divisor and signed overflow.
module div_fast_path
  import div_pkg::*;
(
  input  logic [1:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_hit,
  output logic [31:0] o_result
);

  div_op_t w_op;
  logic    w_div_zero;
  logic    w_ovf;

  always_comb begin
    w_op       = div_op_t'(i_op);
    w_div_zero = (i_b == '0);
    w_ovf      = w_op.is_signed & (i_a == INT_MIN) & (i_b == '1);
    o_hit      = w_div_zero | w_ovf;
    o_result   = '0;
    if (w_div_zero) begin
      o_result = sel_result(w_op, DIV_ZERO_Q, i_a);
    end else if (w_ovf) begin
      o_result = sel_result(w_op, INT_MIN, '0);
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// EX-stage front end for the iterative divider: issues requests, collects results,
// stalls the pipeline, and drains in-flight divider work after a flush.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int FAST_PATH = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [1:0]  ex_op,
  input  logic [31:0] ex_a,
  input  logic [31:0] ex_b,
  input  logic        ex_ready,
  input  logic        flush,
  output logic        ex_stall,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        div_valid,
  input  logic        div_ready,
  output logic        div_signed,
  output logic [31:0] div_z,
  output logic [31:0] div_d,
  input  logic        out_valid,
  output logic        out_ready,
  input  logic [31:0] div_q,
  input  logic [31:0] div_s
);

  localparam bit FAST_EN = (FAST_PATH != 0);

  div_state_e  r_state;
  div_state_e  w_state_nxt;
  div_op_t     r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_res_data;

  logic        w_latch;
  logic        w_res_load;
  logic [31:0] w_res_nxt;
  logic        w_fast_hit;
  logic [31:0] w_fast_res;
  logic        w_fast_en;

  div_fast_path u_fast (
    .i_op     (ex_op),
    .i_a      (ex_a),
    .i_b      (ex_b),
    .o_hit    (w_fast_hit),
    .o_result (w_fast_res)
  );

  assign w_fast_en = FAST_EN & w_fast_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_res_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_op <= div_op_t'(ex_op);
        r_a  <= ex_a;
        r_b  <= ex_b;
      end
      if (w_res_load) begin
        r_res_data <= w_res_nxt;
      end
    end
  end

  // Flush is tested first everywhere; the kill states ignore it because they
  // only exist to drain a divider transaction that can no longer be cancelled.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_res_load  = 1'b0;
    w_res_nxt   = r_res_data;
    div_valid   = 1'b0;
    out_ready   = 1'b0;
    res_valid   = 1'b0;
    ex_stall    = ex_valid;
    unique case (r_state)
      ST_IDLE: begin
        ex_stall = ex_valid & ~flush;
        if (ex_valid & ~flush) begin
          w_latch = 1'b1;
          if (w_fast_en) begin
            w_res_load  = 1'b1;
            w_res_nxt   = w_fast_res;
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        div_valid = 1'b1;
        if (flush) begin
          w_state_nxt = div_ready ? ST_KILL_WAIT : ST_KILL_REQ;
        end else if (div_ready) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        out_ready = 1'b1;
        if (flush) begin
          w_state_nxt = out_valid ? ST_IDLE : ST_KILL_WAIT;
        end else if (out_valid) begin
          w_res_load  = 1'b1;
          w_res_nxt   = sel_result(r_op, div_q, div_s);
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        res_valid = 1'b1;
        ex_stall  = 1'b0;
        if (ex_ready | flush) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_KILL_REQ: begin
        div_valid = 1'b1;
        if (div_ready) begin
          w_state_nxt = ST_KILL_WAIT;
        end
      end
      ST_KILL_WAIT: begin
        out_ready = 1'b1;
        if (out_valid) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign res_data   = r_res_data;
  assign div_z      = r_a;
  assign div_d      = r_b;
  assign div_signed = r_op.is_signed;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Randomized self-checking bench for div_issue_ctrl with a behavioural divider
// and a RISC-V division reference model.
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [1:0]  ex_op;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic        ex_ready;
  logic        flush;
  logic        ex_stall;
  logic        res_valid;
  logic [31:0] res_data;
  logic        div_valid;
  logic        div_ready;
  logic        div_signed;
  logic [31:0] div_z;
  logic [31:0] div_d;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] div_q;
  logic [31:0] div_s;

  int n_vec = 0;
  int n_bad = 0;
  int cfg_rdy = 0;
  int cfg_lat = 1;
  bit e_busy = 0;
  bit idle_start = 0;

  always #5 clk = ~clk;

  div_issue_ctrl #(.FAST_PATH(1)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .ex_op      (ex_op),
    .ex_a       (ex_a),
    .ex_b       (ex_b),
    .ex_ready   (ex_ready),
    .flush      (flush),
    .ex_stall   (ex_stall),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .div_signed (div_signed),
    .div_z      (div_z),
    .div_d      (div_d),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .div_q      (div_q),
    .div_s      (div_s)
  );

  task automatic chk(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // RISC-V M-extension semantics, returns {quotient, remainder}.
  function automatic logic [63:0] rv_divide(input logic sg, input logic [31:0] z, input logic [31:0] d);
    logic [31:0] q;
    logic [31:0] r;
    int sz;
    int sd;
    if (d == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = z;
    end else if (sg && z == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (sg) begin
      sz = z;
      sd = d;
      q = sz / sd;
      r = sz % sd;
    end else begin
      q = z / d;
      r = z % d;
    end
    return {q, r};
  endfunction

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] t;
    t = rv_divide(op[0], a, b);
    return op[1] ? t[31:0] : t[63:32];
  endfunction

  function automatic bit is_fast(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic check_stall();
    if (!ex_valid) chk("stall_no_instr", ex_stall, 1'b0);
    else if (res_valid) chk("stall_with_result", ex_stall, 1'b0);
    else if (!flush) chk("stall_pending", ex_stall, 1'b1);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      ex_valid = 1'b0; flush = 1'b0; ex_ready = 1'b0;
      @(negedge clk);
      check_stall();
      chk("res_in_gap", res_valid, 1'b0);
    end
  endtask

  // Present one instruction until consumed or flushed at cycle flush_cyc.
  task automatic do_instr(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int flush_cyc, input int rdy_gap);
    logic [31:0] exp;
    bit fast;
    bit fin;
    bit killed;
    int res_cnt;
    int cyc;
    exp = ref_res(op, a, b);
    fast = is_fast(op, a, b);
    fin = 0; killed = 0; res_cnt = 0; cyc = 0;
    while (!fin && cyc < 300) begin
      @(posedge clk); #1;
      ex_valid = 1'b1; ex_op = op; ex_a = a; ex_b = b;
      flush = (cyc == flush_cyc);
      ex_ready = (res_cnt >= rdy_gap);
      @(negedge clk);
      check_stall();
      if (idle_start && cyc == 0) chk("T0_idle", {div_valid, res_valid}, 2'b00);
      if (idle_start && flush_cyc != 0 && cyc == 1) begin
        chk("T1_req", div_valid, !fast);
        chk("T1_fast_res", res_valid, fast);
      end
      if (idle_start && fast) chk("fast_no_req", div_valid, 1'b0);
      if (res_valid) begin
        chk("res_data", res_data, exp);
        res_cnt++;
      end
      if (flush) begin
        fin = 1; killed = 1;
      end else if (res_valid && ex_ready) begin
        fin = 1;
      end
      cyc++;
    end
    chk("instr_completes", fin, 1'b1);
    idle_start = fin && !killed;
  endtask

  // Behavioural divider: request/result handshakes with configurable delays.
  initial begin : divider_env
    bit acc, ret, rst_s;
    bit pend;
    logic [31:0] cz, cd, pz, pd;
    logic csg, psg;
    logic [63:0] qr;
    int age, lat, rd;
    pend = 0; age = 0; lat = 0; rd = 0; qr = '0;
    pz = '0; pd = '0; psg = 1'b0;
    div_ready = 1'b0; out_valid = 1'b0; div_q = '0; div_s = '0;
    forever begin
      @(negedge clk);
      acc = div_valid & div_ready;
      ret = out_valid & out_ready;
      rst_s = rst_n;
      cz = div_z; cd = div_d; csg = div_signed;
      if (rst_n) begin
        if (e_busy) chk("req_while_busy", div_valid, 1'b0);
        if (pend) chk("req_hold", {div_valid, div_signed, div_z, div_d}, {1'b1, psg, pz, pd});
      end
      pend = rst_n & div_valid & ~div_ready;
      pz = cz; pd = cd; psg = csg;
      @(posedge clk); #1;
      if (!rst_s) begin
        e_busy = 0; div_ready = 1'b0; out_valid = 1'b0; age = 0;
      end else begin
        if (ret) begin
          out_valid = 1'b0; e_busy = 0;
        end
        if (acc) begin
          e_busy = 1; div_ready = 1'b0;
          qr = rv_divide(csg, cz, cd);
          lat = (cfg_lat < 0) ? int'($urandom_range(0, 4)) : cfg_lat;
        end
        if (e_busy && !out_valid) begin
          if (lat == 0) begin
            out_valid = 1'b1; div_q = qr[63:32]; div_s = qr[31:0];
          end else begin
            lat--;
          end
        end
        if (!e_busy && div_valid) begin
          if (age == 0) rd = (cfg_rdy < 0) ? int'($urandom_range(0, 3)) : cfg_rdy;
          div_ready = (age >= rd);
          age++;
        end else begin
          div_ready = 1'b0; age = 0;
        end
      end
    end
  end

  initial begin : main
    logic [1:0] op;
    logic [31:0] a, b;
    int k, fl;
    rst_n = 1'b0; ex_valid = 1'b0; ex_op = '0; ex_a = '0; ex_b = '0;
    ex_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {ex_stall, res_valid, div_valid, out_ready}, 4'b0000);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_operands", {div_signed, div_z, div_d}, 65'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_start = 1;

    cfg_rdy = 0; cfg_lat = 1;
    do_instr(2'b01, 32'hFFFF_FFF9, 32'd2, -1, 0);
    gap(1);
    cfg_rdy = 3;
    do_instr(2'b10, 32'd100, 32'd7, -1, 1);
    gap(1);
    cfg_rdy = 0;
    do_instr(2'b01, 32'd5, 32'd0, -1, 0);
    do_instr(2'b11, 32'd5, 32'd0, -1, 0);
    do_instr(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0);
    do_instr(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0);
    do_instr(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0);
    cfg_lat = 4;
    do_instr(2'b00, 32'd50, 32'd5, 3, 0);
    cfg_lat = 1;
    do_instr(2'b00, 32'd9, 32'd3, -1, 0);
    cfg_rdy = 3;
    do_instr(2'b01, 32'd1000, 32'd3, 2, 0);
    cfg_rdy = 0;
    do_instr(2'b10, 32'd1000, 32'd3, -1, 0);
    do_instr(2'b01, 32'd5, 32'd0, 2, 5);
    gap(2);

    // Reset while the divider owes a result.
    cfg_lat = 6;
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_op = 2'b00; ex_a = 32'd100; ex_b = 32'd7; flush = 1'b0; ex_ready = 1'b0;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_reset_wait", out_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_op_reset", {div_valid, out_ready, res_valid, ex_stall}, 4'b0000);
    idle_start = 1;
    cfg_lat = 1;
    do_instr(2'b01, 32'd77, 32'hFFFF_FFF5, -1, 0);

    cfg_rdy = -1; cfg_lat = -1;
    for (int i = 0; i < 250; i++) begin
      op = 2'($urandom);
      k = $urandom_range(0, 7);
      a = (k == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      if (k == 1) begin
        a = 32'h8000_0000; b = 32'hFFFF_FFFF;
      end
      fl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 6)) : -1;
      do_instr(op, a, b, fl, $urandom_range(0, 2));
      gap($urandom_range(0, 2));
    end
    gap(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Execute-stage front end for the iterative divider. It latches a DIV.W/DIV.WU/MOD.W/MOD.WU request from the pipeline and drives the divider's valid/ready request channel.
- It consumes the divider's out_valid/out_ready result channel and selects either the quotient or the remainder.
- It stalls the pipeline until the result is delivered.
- It discards in-flight results on flush and resolves divide-by-zero and signed overflow locally, without using the divider.

Parameters:
- FAST_PATH, 1, when 1 divide-by-zero and signed overflow (0x8000_0000 / -1) complete locally.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- ex_valid  in  1  divide instruction present in EX
- ex_op  in  2  bit0 = signed, bit1 = mod (remainder select)
- ex_a  in  32  dividend
- ex_b  in  32  divisor
- ex_ready  in  1  pipeline consumes result this cycle
- flush  in  1  kill current EX instruction
- ex_stall  out  1  hold EX stage
- res_valid  out  1  result valid
- res_data  out  32  selected result
- div_valid  out  1  request to divider
- div_ready  in  1  divider accepts request
- div_signed  out  1  signed divide
- div_z  out  32  dividend to divider
- div_d  out  32  divisor to divider
- out_valid  in  1  divider result valid
- out_ready  out  1  accept divider result
- div_q  in  32  divider quotient
- div_s  in  32  divider remainder

Behaviour:
- Reset values: state = IDLE, div_valid = 0, out_ready = 0, res_valid = 0, res_data = 0, ex_stall = 0. Operand registers are cleared to 0.
- States: IDLE, REQ, WAIT, DONE, KILL_REQ, KILL_WAIT.
- IDLE:
  - On ex_valid & ~flush: latch op, a and b.
  - If FAST_PATH and (b == 0 or (signed & a == 0x8000_0000 & b == 0xFFFF_FFFF)): write the fast result into res_data and go to DONE.
  - Otherwise go to REQ.
- Fast results:
  - b == 0: quotient = 0xFFFF_FFFF, remainder = a.
  - Signed overflow: quotient = 0x8000_0000, remainder = 0.
- REQ:
  - div_valid = 1; div_z, div_d and div_signed come from the latched registers and are stable while in REQ.
  - div_ready = 1 → WAIT.
  - flush → KILL_REQ, or KILL_WAIT if div_ready is high in the same cycle.
  - div_valid is never deasserted before the handshake.
- WAIT:
  - out_ready = 1.
  - out_valid → res_data <= mod ? div_s : div_q, then go to DONE.
  - flush with no out_valid → KILL_WAIT.
  - flush and out_valid in the same cycle → result discarded, go to IDLE.
- DONE:
  - res_valid = 1 and res_data is held.
  - ex_ready | flush → IDLE. No new request is accepted in that same cycle.
- KILL_REQ: div_valid = 1 until div_ready, then → KILL_WAIT.
- KILL_WAIT: out_ready = 1; out_valid → IDLE, result dropped.
- While in KILL_REQ or KILL_WAIT, ex_valid is ignored and ex_stall = ex_valid, so a new divide waits until the drain completes.
- ex_stall = ex_valid & ~(state == DONE), except in IDLE, where ex_stall = ex_valid & ~flush.
- res_valid is asserted only in DONE.
- Latency: latched at cycle T; div_valid high at T+1. The result is visible on the cycle after out_valid.
- Fast-path latency: res_valid high at T+1.
- Flush has priority over ex_valid and ex_ready in all states.
- rst_n low mid-operation returns to IDLE immediately. The divider is reset by the same rst_n, so no drain is needed.

Decomposition:
- Shared package div_pkg holds:
  - the typedef div_op_t (signed, mod);
  - the state enum;
  - the constants DIV_ZERO_Q = 32'hFFFF_FFFF and INT_MIN = 32'h8000_0000.
- Sub-module div_fast_path (combinational):
  - detects the zero-divisor and signed-overflow cases;
  - produces the fast result.
- The FSM stays in div_issue_ctrl.

Test Plan:
- div.w a = -7 (0xFFFF_FFF9), b = 2 (divider model returns q = 0xFFFF_FFFD):
  - div_valid rises one cycle after ex_valid;
  - res_data = 0xFFFF_FFFD;
  - ex_stall deasserts with res_valid.
- mod.wu a = 100, b = 7, with div_ready delayed 3 cycles:
  - div_valid is held steady for the full 3 cycles;
  - res_data = 2.
- div.w a = 5, b = 0:
  - no div_valid is issued;
  - res_valid at T+1 with res_data = 0xFFFF_FFFF.
- mod.w a = 5, b = 0:
  - no div_valid is issued;
  - res_data = 5.
- div.w a = 0x8000_0000, b = 0xFFFF_FFFF:
  - res_data = 0x8000_0000 with no divider request.
- flush in WAIT, then a new div.wu 9/3 on the next cycle:
  - the stale out_valid is consumed and dropped;
  - the new request is issued only after the drain;
  - res_data = 3.
